// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default widths for pipeline stage registers
package pipe_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_t;
  localparam int DATA_W_DEF = 128;
  localparam int CTRL_W_DEF = 16;
  localparam int CNT_W_DEF  = 16;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  always_ff @(posedge clk_i)
    if (!rst_n) cnt_o <= '0;
    else if (clr_i) cnt_o <= '0;
    else if (inc_i && cnt_o != '1) cnt_o <= cnt_o + CNT_W'(1);
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid buffer, flush and CPI counters
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CTRL_W     = CTRL_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              cnt_clr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);
  state_t state;
  logic [DATA_W-1:0] main_d, skid_d;
  logic [CTRL_W-1:0] main_c, skid_c;
  logic accept, drain;
  assign in_ready_o  = state != ST_FULL;
  assign out_valid_o = state == ST_ONE || state == ST_FULL;
  assign accept      = in_valid_i && in_ready_o;
  assign drain       = out_valid_o && out_ready_i;
  assign out_data_o  = main_d;
  assign out_ctrl_o  = main_c;
  // main_c is cleared on every transition to empty so invalid cycles always present a bubble
  always_ff @(posedge clk_i)
    if (!rst_n) begin
      state  <= ST_EMPTY;
      main_d <= '0;
      main_c <= '0;
      skid_d <= '0;
      skid_c <= '0;
    end else if (flush_i) begin
      state  <= ST_EMPTY;
      main_c <= '0;
      skid_c <= '0;
      if (CLEAR_DATA) begin
        main_d <= '0;
        skid_d <= '0;
      end
    end else
      case (state)
        ST_EMPTY:
          if (accept) begin
            state  <= ST_ONE;
            main_d <= in_data_i;
            main_c <= in_ctrl_i;
          end
        ST_ONE:
          if (accept && drain) begin
            main_d <= in_data_i;
            main_c <= in_ctrl_i;
          end else if (accept) begin
            state  <= ST_FULL;
            skid_d <= in_data_i;
            skid_c <= in_ctrl_i;
          end else if (drain) begin
            state  <= ST_EMPTY;
            main_c <= '0;
            if (CLEAR_DATA) main_d <= '0;
          end
        ST_FULL:
          if (drain) begin
            state  <= ST_ONE;
            main_d <= skid_d;
            main_c <= skid_c;
          end
        default: begin
          state  <= ST_EMPTY;
          main_c <= '0;
          skid_c <= '0;
          if (CLEAR_DATA) main_d <= '0;
        end
      endcase
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .clr_i (cnt_clr_i),
    .inc_i (out_valid_o && !out_ready_i),
    .cnt_o (stall_cnt_o)
  );
  sat_counter #(.CNT_W(CNT_W)) u_bubble (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .clr_i (cnt_clr_i),
    .inc_i (!out_valid_o),
    .cnt_o (bubble_cnt_o)
  );
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed checks of two stage instances (clearing/16-bit counters, holding/4-bit counters) on shared stimulus
module tb_pipe_stage_skid;
  logic clk_i = 0, rst_n = 0, flush_i = 0, cnt_clr_i = 0, in_valid_i = 0, out_ready_i = 0;
  logic [127:0] in_data_i = '0;
  logic [15:0] in_ctrl_i = '0;
  logic a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [127:0] a_data, b_data;
  logic [15:0] a_ctrl, b_ctrl, a_stall, a_bubble;
  logic [3:0] b_stall, b_bubble;
  int n_assert = 0, n_fail = 0;
  always #5 clk_i = ~clk_i;
  pipe_stage_skid u_a (
    .clk_i(clk_i), .rst_n(rst_n), .flush_i(flush_i), .cnt_clr_i(cnt_clr_i),
    .in_valid_i(in_valid_i), .in_ready_o(a_in_ready), .in_data_i(in_data_i), .in_ctrl_i(in_ctrl_i),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready_i), .out_data_o(a_data), .out_ctrl_o(a_ctrl),
    .stall_cnt_o(a_stall), .bubble_cnt_o(a_bubble)
  );
  pipe_stage_skid #(.CNT_W(4), .CLEAR_DATA(1'b0)) u_b (
    .clk_i(clk_i), .rst_n(rst_n), .flush_i(flush_i), .cnt_clr_i(cnt_clr_i),
    .in_valid_i(in_valid_i), .in_ready_o(b_in_ready), .in_data_i(in_data_i), .in_ctrl_i(in_ctrl_i),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready_i), .out_data_o(b_data), .out_ctrl_o(b_ctrl),
    .stall_cnt_o(b_stall), .bubble_cnt_o(b_bubble)
  );
  function automatic logic [15:0] cf(input logic [127:0] d);
    return d[15:0] ^ 16'hC000;
  endfunction
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask
  task automatic push(input logic v, input logic [127:0] d);
    in_valid_i = v;
    in_data_i  = d;
    in_ctrl_i  = cf(d);
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    step(2);
    chk("rst_valid", a_out_valid, 0);
    chk("rst_ready", a_in_ready, 1);
    chk("rst_data", a_data, 0);
    chk("rst_ctrl", a_ctrl, 0);
    chk("rst_stall", a_stall, 0);
    chk("rst_bubble", a_bubble, 0);
    rst_n = 1;
    out_ready_i = 1;
    for (int k = 1; k <= 4; k++) begin
      push(1, 128'(k));
      step();
      chk("stream_valid", a_out_valid, 1);
      chk("stream_data", a_data, 128'(k));
      chk("stream_ctrl", a_ctrl, cf(128'(k)));
      chk("stream_ready", a_in_ready, 1);
    end
    push(0, 0);
    step();
    chk("stream_end_valid", a_out_valid, 0);
    chk("stream_end_ctrl", a_ctrl, 0);
    chk("stream_end_data", a_data, 0);
    chk("hold_data_b", b_data, 128'd4);
    out_ready_i = 0;
    push(1, 128'hA);
    step();
    chk("bp_one_ready", a_in_ready, 1);
    chk("bp_one_data", a_data, 128'hA);
    push(1, 128'hB);
    step();
    chk("bp_full_ready", a_in_ready, 0);
    chk("bp_full_data", a_data, 128'hA);
    push(0, 0);
    step();
    chk("bp_stable_data", a_data, 128'hA);
    chk("bp_stable_ctrl", a_ctrl, cf(128'hA));
    out_ready_i = 1;
    step();
    chk("bp_drain1_data", a_data, 128'hB);
    chk("bp_drain1_ready", a_in_ready, 1);
    step();
    chk("bp_drain2_valid", a_out_valid, 0);
    out_ready_i = 0;
    push(1, 128'hC);
    step();
    push(1, 128'hD);
    step();
    chk("fl_full_ready", a_in_ready, 0);
    flush_i = 1;
    push(1, 128'hE);
    step();
    chk("fl_valid", a_out_valid, 0);
    chk("fl_ctrl", a_ctrl, 0);
    chk("fl_data", a_data, 0);
    chk("fl_ctrl_b", b_ctrl, 0);
    flush_i = 0;
    push(0, 0);
    out_ready_i = 1;
    step();
    chk("fl_after_valid", a_out_valid, 0);
    chk("fl_after_data", a_data, 0);
    out_ready_i = 0;
    cnt_clr_i = 1;
    push(1, 128'hF);
    step();
    chk("cnt_clr0_stall", a_stall, 0);
    chk("cnt_clr0_bubble", a_bubble, 0);
    cnt_clr_i = 0;
    push(0, 0);
    step(5);
    out_ready_i = 1;
    step();
    step(3);
    chk("cnt_stall", a_stall, 5);
    chk("cnt_bubble", a_bubble, 3);
    chk("cnt_stall_b", b_stall, 5);
    chk("cnt_bubble_b", b_bubble, 3);
    cnt_clr_i = 1;
    step();
    chk("cnt_clr_stall", a_stall, 0);
    chk("cnt_clr_bubble", a_bubble, 0);
    cnt_clr_i = 0;
    out_ready_i = 0;
    push(1, 128'h10);
    step();
    push(0, 0);
    step(20);
    chk("sat_stall_b", b_stall, 15);
    chk("sat_stall_a", a_stall, 20);
    chk("sat_bubble_a", a_bubble, 1);
    push(1, 128'h11);
    step();
    push(0, 0);
    chk("mr_full_ready", a_in_ready, 0);
    rst_n = 0;
    step();
    chk("mr_valid", a_out_valid, 0);
    chk("mr_ready", a_in_ready, 1);
    chk("mr_data", a_data, 0);
    chk("mr_data_b", b_data, 0);
    chk("mr_ctrl", a_ctrl, 0);
    chk("mr_stall_b", b_stall, 0);
    rst_n = 1;
    out_ready_i = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mr_post_valid", a_out_valid, 0);
    end
    push(1, 128'h55);
    step();
    chk("cd_b_data", b_data, 128'h55);
    push(0, 0);
    step();
    chk("cd_b_valid", b_out_valid, 0);
    chk("cd_b_ctrl", b_ctrl, 0);
    chk("cd_b_hold", b_data, 128'h55);
    chk("cd_a_data", a_data, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
